instruction_fetch_unit: RTL and testbench

//  Reader side of the 28-bit instruction ROM. Drives the ROM address (PC) and samples the

---
 rtl/instruction_fetch_unit_if.sv | 45 ++++
 rtl/instruction_fetch_unit.sv | 100 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle for the instruction fetch unit: ROM read port plus the
// valid/ready issue port toward the execute/register-file datapath.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int INSN_W = 28
);
  logic [ADDR_W-1:0] oAddress;
  logic [INSN_W-1:0] iInstruction;
  logic              oValid;
  logic              iReady;
  logic [3:0]        oOperation;
  logic [7:0]        oDest;
  logic [7:0]        oSrc1;
  logic [7:0]        oSrc0;
  logic [15:0]       oImmediate;
  logic              oBusy;

  // Fetch unit side: drives the ROM address and the issued fields.
  modport master (
    output oAddress,
    input  iInstruction,
    output oValid,
    input  iReady,
    output oOperation,
    output oDest,
    output oSrc1,
    output oSrc0,
    output oImmediate,
    output oBusy
  );

  // ROM/datapath side: returns the instruction word and accepts issues.
  modport slave (
    input  oAddress,
    output iInstruction,
    input  oValid,
    output iReady,
    input  oOperation,
    input  oDest,
    input  oSrc1,
    input  oSrc0,
    input  oImmediate,
    input  oBusy
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: walks the instruction ROM with a PC, executes NOP
// (timed delay) and JMP (unconditional branch) locally, and issues every
// other word to the datapath through a valid/ready handshake.
module instruction_fetch_unit #(
  parameter int         ADDR_W = 16,
  parameter int         INSN_W = 28,
  parameter logic [3:0] OP_NOP = 4'hE,
  parameter logic [3:0] OP_JMP = 4'hF
) (
  input logic                  Clock,
  input logic                  Reset,
  instruction_fetch_unit_if.master bus
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] DELAY = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INSN_W-1:0] ir_q, ir_d;
  logic [23:0]       count_q, count_d;

  logic [3:0]        fetchOpcode;
  logic [23:0]       nopCount;
  logic [ADDR_W-1:0] jmpTarget;
  logic [ADDR_W-1:0] pcNext;

  assign fetchOpcode = bus.iInstruction[27:24];
  assign nopCount    = bus.iInstruction[23:0];
  assign jmpTarget   = {{(ADDR_W-8){1'b0}}, bus.iInstruction[23:16]};
  assign pcNext      = pc_q + ADDR_W'(1);

  // Next-state decode. IR only captures words that are going to be issued,
  // so the field outputs keep the last issued instruction across NOPs/JMPs.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    count_d = count_q;
    case (state_q)
      FETCH: begin
        if (fetchOpcode == OP_NOP) begin
          pc_d = pcNext;
          if (nopCount > 24'd1) begin
            state_d = DELAY;
            count_d = nopCount - 24'd1;
          end
        end else if (fetchOpcode == OP_JMP) begin
          pc_d = jmpTarget;
        end else begin
          ir_d    = bus.iInstruction;
          pc_d    = pcNext;
          state_d = ISSUE;
        end
      end
      DELAY: begin
        if (count_q == 24'd1) begin
          state_d = FETCH;
          count_d = 24'd0;
        end else begin
          count_d = count_q - 24'd1;
        end
      end
      ISSUE: begin
        if (bus.iReady) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State registers; reset wins over every state and aborts any delay or issue.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      count_q <= count_d;
    end
  end

  assign bus.oAddress   = pc_q;
  assign bus.oValid     = (state_q == ISSUE);
  assign bus.oBusy      = (state_q == DELAY);
  assign bus.oOperation = ir_q[27:24];
  assign bus.oDest      = ir_q[23:16];
  assign bus.oSrc1      = ir_q[15:8];
  assign bus.oSrc0      = ir_q[7:0];
  assign bus.oImmediate = ir_q[15:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a behavioural ROM feeds the
// fetch port, and each scenario task checks the hand-derived cycle behaviour.
module tb_instruction_fetch_unit;

  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h3;
  localparam logic [3:0] OP_LED = 4'h5;
  localparam logic [3:0] OP_NOP = 4'hE;
  localparam logic [3:0] OP_JMP = 4'hF;

  logic Clock = 1'b0;
  logic Reset;
  int   assertCount = 0;
  int   failCount   = 0;

  logic [27:0] rom [0:65535];

  instruction_fetch_unit_if #(.ADDR_W(16), .INSN_W(28)) bus ();

  assign bus.iInstruction = rom[bus.oAddress];

  instruction_fetch_unit #(
    .ADDR_W(16),
    .INSN_W(28),
    .OP_NOP(OP_NOP),
    .OP_JMP(OP_JMP)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  // Free-running 10 ns clock.
  always #5 Clock = ~Clock;

  // Guard against a stuck run.
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clearRom(input logic [27:0] fill);
    for (int a = 0; a < 65536; a++) rom[a] = fill;
  endtask

  // Leaves the bench at the negedge right after reset release (first FETCH cycle).
  task automatic startRun();
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    clearRom({OP_STO, 24'h123456});
    bus.iReady = 1'b0;
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    assertCount++;
    if ({bus.oAddress, bus.oValid, bus.oBusy} !== {16'h0000, 1'b0, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL reset_ctrl: addr=%h valid=%b busy=%b want addr=0000 valid=0 busy=0",
               bus.oAddress, bus.oValid, bus.oBusy);
    end
    assertCount++;
    if ({bus.oOperation, bus.oDest, bus.oSrc1, bus.oSrc0, bus.oImmediate} !== 44'h0) begin
      failCount++;
      $display("[TB] FAIL reset_fields: op=%h dest=%h src1=%h src0=%h imm=%h want all 0",
               bus.oOperation, bus.oDest, bus.oSrc1, bus.oSrc0, bus.oImmediate);
    end
    Reset = 1'b0;
  endtask

  task automatic test_sto_issue();
    clearRom({OP_LED, 24'h0});
    rom[0] = {OP_STO, 8'h00, 16'h8000};
    bus.iReady = 1'b0;
    startRun();
    assertCount++;
    if (bus.oValid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL sto_fetch_valid: got %b want 0", bus.oValid);
    end
    @(negedge Clock);
    assertCount++;
    if ({bus.oValid, bus.oOperation, bus.oDest, bus.oImmediate, bus.oAddress} !==
        {1'b1, OP_STO, 8'h00, 16'h8000, 16'h0001}) begin
      failCount++;
      $display("[TB] FAIL sto_issue: valid=%b op=%h dest=%h imm=%h pc=%h want 1 1 00 8000 0001",
               bus.oValid, bus.oOperation, bus.oDest, bus.oImmediate, bus.oAddress);
    end
    bus.iReady = 1'b1;
    @(negedge Clock);
    bus.iReady = 1'b0;
    assertCount++;
    if ({bus.oValid, bus.oAddress} !== {1'b0, 16'h0001}) begin
      failCount++;
      $display("[TB] FAIL sto_after_accept: valid=%b pc=%h want 0 0001", bus.oValid, bus.oAddress);
    end
  endtask

  task automatic test_nop_delay();
    int   busyCount = 0;
    int   fetchCycle = 0;
    logic validSeen = 1'b0;
    logic overlap = 1'b0;
    logic [15:0] fetchAddr = 16'hxxxx;
    clearRom({OP_LED, 24'h0});
    rom[0] = {OP_NOP, 24'd4000};
    bus.iReady = 1'b1;
    startRun();
    for (int c = 1; c <= 4100; c++) begin
      if (c > 1) @(negedge Clock);
      if (bus.oBusy && bus.oValid) overlap = 1'b1;
      if (bus.oValid) validSeen = 1'b1;
      if (bus.oBusy) begin
        busyCount++;
      end else if (c > 1) begin
        fetchCycle = c;
        fetchAddr  = bus.oAddress;
        break;
      end
    end
    assertCount++;
    if (busyCount !== 3999) begin
      failCount++;
      $display("[TB] FAIL nop4000_busy_cycles: got %0d want 3999", busyCount);
    end
    assertCount++;
    if ({fetchCycle, fetchAddr} !== {32'd4001, 16'h0001}) begin
      failCount++;
      $display("[TB] FAIL nop4000_next_fetch: cycle=%0d pc=%h want cycle=4001 pc=0001",
               fetchCycle, fetchAddr);
    end
    assertCount++;
    if ({validSeen, overlap} !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL nop4000_no_valid: validSeen=%b overlap=%b want 0 0", validSeen, overlap);
    end
  endtask

  task automatic test_short_nops();
    clearRom({OP_LED, 24'h0});
    rom[0] = {OP_NOP, 24'd0};
    rom[1] = {OP_NOP, 24'd1};
    rom[2] = {OP_NOP, 24'd2};
    rom[3] = {OP_LED, 8'h3C, 16'h0};
    bus.iReady = 1'b1;
    startRun();
    @(negedge Clock);
    assertCount++;
    if ({bus.oAddress, bus.oBusy, bus.oValid} !== {16'h0001, 1'b0, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL nop0_single: pc=%h busy=%b valid=%b want 0001 0 0",
               bus.oAddress, bus.oBusy, bus.oValid);
    end
    @(negedge Clock);
    assertCount++;
    if ({bus.oAddress, bus.oBusy, bus.oValid} !== {16'h0002, 1'b0, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL nop1_single: pc=%h busy=%b valid=%b want 0002 0 0",
               bus.oAddress, bus.oBusy, bus.oValid);
    end
    @(negedge Clock);
    assertCount++;
    if ({bus.oAddress, bus.oBusy, bus.oValid} !== {16'h0003, 1'b1, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL nop2_busy: pc=%h busy=%b valid=%b want 0003 1 0",
               bus.oAddress, bus.oBusy, bus.oValid);
    end
    @(negedge Clock);
    assertCount++;
    if ({bus.oAddress, bus.oBusy, bus.oValid} !== {16'h0003, 1'b0, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL nop2_end: pc=%h busy=%b valid=%b want 0003 0 0",
               bus.oAddress, bus.oBusy, bus.oValid);
    end
    @(negedge Clock);
    assertCount++;
    if ({bus.oValid, bus.oOperation, bus.oDest} !== {1'b1, OP_LED, 8'h3C}) begin
      failCount++;
      $display("[TB] FAIL nop_chain_issue: valid=%b op=%h dest=%h want 1 5 3c",
               bus.oValid, bus.oOperation, bus.oDest);
    end
  endtask

  task automatic test_jmp_loop();
    logic [3:0]  seen [8];
    logic [3:0]  expOps [8];
    int          n = 0;
    int          jumps = 0;
    logic [15:0] prevAddr = 16'hxxxx;
    logic        prevIdle = 1'b0;
    expOps[0] = OP_STO; expOps[1] = OP_STO; expOps[2] = OP_MUL; expOps[3] = OP_LED;
    expOps[4] = OP_STO; expOps[5] = OP_STO; expOps[6] = OP_MUL; expOps[7] = OP_LED;
    for (int i = 0; i < 8; i++) seen[i] = 4'h0;
    clearRom({OP_LED, 24'h0});
    rom[0] = {OP_STO, 8'h01, 16'h0011};
    rom[1] = {OP_STO, 8'h02, 16'h0022};
    rom[2] = {OP_NOP, 24'd3};
    rom[3] = {OP_MUL, 8'h03, 8'h01, 8'h02};
    rom[4] = {OP_NOP, 24'd0};
    rom[5] = {OP_LED, 8'h00, 8'h03, 8'h00};
    rom[6] = {OP_NOP, 24'd2};
    rom[7] = {OP_JMP, 8'd0, 16'h0};
    bus.iReady = 1'b1;
    startRun();
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge Clock);
      if (prevIdle && prevAddr == 16'h0007) begin
        jumps++;
        assertCount++;
        if ({bus.oAddress, bus.oValid, bus.oBusy} !== {16'h0000, 1'b0, 1'b0}) begin
          failCount++;
          $display("[TB] FAIL jmp_target: pc=%h valid=%b busy=%b want 0000 0 0",
                   bus.oAddress, bus.oValid, bus.oBusy);
        end
      end
      if (bus.oValid && n < 8) begin
        seen[n] = bus.oOperation;
        n++;
      end
      prevAddr = bus.oAddress;
      prevIdle = !bus.oValid && !bus.oBusy;
    end
    assertCount++;
    if ({n, jumps} !== {32'd8, 32'd2}) begin
      failCount++;
      $display("[TB] FAIL jmp_loop_counts: issues=%0d jumps=%0d want 8 2", n, jumps);
    end
    for (int i = 0; i < 8; i++) begin
      assertCount++;
      if (seen[i] !== expOps[i]) begin
        failCount++;
        $display("[TB] FAIL jmp_loop_order[%0d]: got %h want %h", i, seen[i], expOps[i]);
      end
    end
  endtask

  task automatic test_jmp_self();
    logic bad = 1'b0;
    clearRom({OP_LED, 24'h0});
    rom[0] = {OP_JMP, 8'd0, 16'h0};
    bus.iReady = 1'b1;
    startRun();
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      if (bus.oAddress !== 16'h0000 || bus.oValid !== 1'b0 || bus.oBusy !== 1'b0) bad = 1'b1;
    end
    assertCount++;
    if (bad !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL jmp_self_loop: left PC 0 or raised valid/busy (bad=%b want 0)", bad);
    end
  endtask

  task automatic test_back_to_back();
    clearRom({OP_LED, 24'h0});
    rom[0] = {OP_MUL, 8'h12, 8'h34, 8'h56};
    rom[1] = {OP_LED, 8'hA5, 16'h0};
    bus.iReady = 1'b0;
    startRun();
    @(negedge Clock);
    for (int k = 0; k < 10; k++) begin
      assertCount++;
      if ({bus.oValid, bus.oOperation, bus.oDest, bus.oSrc1, bus.oSrc0, bus.oAddress} !==
          {1'b1, OP_MUL, 8'h12, 8'h34, 8'h56, 16'h0001}) begin
        failCount++;
        $display("[TB] FAIL stall_hold[%0d]: valid=%b op=%h d=%h s1=%h s0=%h pc=%h want 1 3 12 34 56 0001",
                 k, bus.oValid, bus.oOperation, bus.oDest, bus.oSrc1, bus.oSrc0, bus.oAddress);
      end
      if (k < 9) @(negedge Clock);
    end
    bus.iReady = 1'b1;
    @(negedge Clock);
    bus.iReady = 1'b0;
    assertCount++;
    if ({bus.oValid, bus.oAddress, bus.oOperation, bus.oDest} !==
        {1'b0, 16'h0001, OP_MUL, 8'h12}) begin
      failCount++;
      $display("[TB] FAIL accept_to_fetch: valid=%b pc=%h op=%h dest=%h want 0 0001 3 12",
               bus.oValid, bus.oAddress, bus.oOperation, bus.oDest);
    end
    @(negedge Clock);
    @(negedge Clock);
    assertCount++;
    if ({bus.oValid, bus.oOperation, bus.oDest, bus.oAddress} !==
        {1'b1, OP_LED, 8'hA5, 16'h0002}) begin
      failCount++;
      $display("[TB] FAIL next_issue_held: valid=%b op=%h dest=%h pc=%h want 1 5 a5 0002",
               bus.oValid, bus.oOperation, bus.oDest, bus.oAddress);
    end
  endtask

  task automatic test_reset_abort();
    clearRom({OP_LED, 24'h0});
    rom[0] = {OP_NOP, 24'd4000};
    bus.iReady = 1'b1;
    startRun();
    repeat (100) @(negedge Clock);
    assertCount++;
    if (bus.oBusy !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL delay100_busy: got %b want 1", bus.oBusy);
    end
    Reset = 1'b1;
    @(negedge Clock);
    assertCount++;
    if ({bus.oBusy, bus.oValid, bus.oAddress} !== {1'b0, 1'b0, 16'h0000}) begin
      failCount++;
      $display("[TB] FAIL reset_mid_delay: busy=%b valid=%b pc=%h want 0 0 0000",
               bus.oBusy, bus.oValid, bus.oAddress);
    end
    Reset = 1'b0;
    @(negedge Clock);
    assertCount++;
    if ({bus.oBusy, bus.oAddress} !== {1'b1, 16'h0001}) begin
      failCount++;
      $display("[TB] FAIL restart_after_reset: busy=%b pc=%h want 1 0001", bus.oBusy, bus.oAddress);
    end
    rom[0] = {OP_MUL, 8'h9A, 8'hBC, 8'hDE};
    bus.iReady = 1'b0;
    startRun();
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    assertCount++;
    if ({bus.oValid, bus.oAddress, bus.oOperation, bus.oDest} !== {1'b0, 16'h0000, 4'h0, 8'h00}) begin
      failCount++;
      $display("[TB] FAIL reset_mid_issue: valid=%b pc=%h op=%h dest=%h want 0 0000 0 00",
               bus.oValid, bus.oAddress, bus.oOperation, bus.oDest);
    end
  endtask

  task automatic test_pc_wrap();
    logic reached = 1'b0;
    clearRom({OP_NOP, 24'd0});
    rom[16'hFFFE] = {OP_LED, 8'h66, 16'h0};
    rom[16'hFFFF] = {OP_LED, 8'h77, 16'h0};
    bus.iReady = 1'b1;
    startRun();
    for (int c = 0; c < 70000; c++) begin
      if (bus.oAddress === 16'hFFFF && bus.oValid === 1'b0) begin
        reached = 1'b1;
        break;
      end
      @(negedge Clock);
    end
    assertCount++;
    if (reached !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL wrap_reach_ffff: got %b want 1", reached);
    end
    @(negedge Clock);
    assertCount++;
    if ({bus.oValid, bus.oOperation, bus.oDest, bus.oAddress} !=={1'b1, OP_LED, 8'h77, 16'h0000}) begin
      failCount++;
      $display("[TB] FAIL wrap_issue: valid=%b op=%h dest=%h pc=%h want 1 5 77 0000",
               bus.oValid, bus.oOperation, bus.oDest, bus.oAddress);
    end
    @(negedge Clock);
    @(negedge Clock);
    assertCount++;
    if ({bus.oValid, bus.oBusy, bus.oAddress} !== {1'b0, 1'b0, 16'h0001}) begin
      failCount++;
      $display("[TB] FAIL wrap_refetch: valid=%b busy=%b pc=%h want 0 0 0001",
               bus.oValid, bus.oBusy, bus.oAddress);
    end
  endtask

  initial begin
    Reset = 1'b1;
    bus.iReady = 1'b0;
    $display("[TB] instruction_fetch_unit directed test start");
    test_reset();
    test_sto_issue();
    test_nop_delay();
    test_short_nops();
    test_jmp_loop();
    test_jmp_self();
    test_back_to_back();
    test_reset_abort();
    test_pc_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
